mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_copy_pkg.sv | 25 ++
 rtl/mem_copy_master_order_checker.sv | 49 ++++
 rtl/mem_copy_master.sv | 197 +++++++++++++++++++
 tb/tb_mem_copy_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared definitions for the mem_copy_master block:
//   state_t     - copy FSM state encoding (IDLE / READ / WRITE / FIN)
//   WORD_BYTES  - byte stride between consecutive 32-bit words
//   word_addr() - byte address of word 'idx' relative to 'base' (mod 2^32)
// -----------------------------------------------------------------------------
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Plain 32-bit addition: a wrap past 0xFFFFFFFC silently continues at 0.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx * WORD_BYTES);
  endfunction

endpackage

// File: rtl/mem_copy_master_order_checker.sv
// -----------------------------------------------------------------------------
// order_checker
// Watches the stream of words captured by the copy engine and raises a sticky
// flag when a word is smaller (signed) than the word captured before it.
// Only instantiated when MEM_COPY_ORDER_CHECK_EN is defined.
//
// Ports:
//   clk   in  1   clock, rising edge
//   reset in  1   synchronous active-high reset
//   clear in  1   forget the previous word and clear the flag (new copy)
//   valid in  1   'data' is a newly captured word this cycle
//   data  in  32  captured word
//   err   out 1   sticky out-of-order flag
// -----------------------------------------------------------------------------
module order_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [31:0] data,
  output logic        err
);

  logic [31:0] prev_q;
  logic        have_prev_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (clear) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (valid) begin
      // The first word of a copy has nothing to be compared against.
      if (have_prev_q && ($signed(data) < $signed(prev_q))) begin
        err_q <= 1'b1;
      end
      prev_q      <= data;
      have_prev_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Word-by-word memory copy engine on a simple single-cycle memory bus
// (combinational read responder). Each word takes one READ cycle followed by
// one WRITE cycle; a one-cycle done pulse marks completion.
//
// Optional feature: define MEM_COPY_ORDER_CHECK_EN to enable a signed
// ascending-order check on the source words (err_order). Without it err_order
// is tied low and no checker logic exists; the port list is identical.
//
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset
//   start      in  1      begin a copy (only honoured in IDLE)
//   abort      in  1      abandon an active copy (READ/WRITE), no done pulse
//   src_base   in  32     source byte address (bits [1:0] ignored)
//   dst_base   in  32     destination byte address (bits [1:0] ignored)
//   length     in  LEN_W  number of 32-bit words
//   busy       out 1      high in READ or WRITE
//   done       out 1      one-cycle completion pulse
//   err_order  out 1      sticky: source words not ascending (signed)
//   Address    out 32     bus byte address (0 when idle)
//   Write_data out 32     bus write data (0 when idle)
//   MemRead    out 1      bus read strobe
//   MemWrite   out 1      bus write strobe
//   Read_data  in  32     bus read data, valid in the MemRead cycle
// -----------------------------------------------------------------------------
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             err_order,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      Read_data
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;

  // Bus-facing outputs are registered: they are computed from the state the
  // FSM is about to enter, so they are valid for the whole of that state.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             active;

  assign active = (state_q == READ) || (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = {src_base[31:2], 2'b00};
          dst_d   = {dst_base[31:2], 2'b00};
          len_d   = length;
          idx_d   = '0;
          state_d = (length == '0) ? FIN : READ;
        end
      end
      READ: begin
        data_d  = Read_data;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + LEN_W'(1);
        state_d = (idx_q == (len_q - LEN_W'(1))) ? FIN : READ;
      end
      FIN: begin
        // Done is registered, so it shows in the cycle after FIN.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever transition the copy would have taken.
    if (abort && active) begin
      state_d = IDLE;
      idx_d   = idx_q;
      data_d  = data_q;
    end

    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    busy_d      = 1'b0;

    unique case (state_d)
      READ: begin
        busy_d     = 1'b1;
        mem_read_d = 1'b1;
        addr_d     = word_addr(src_d, 32'(idx_d));
      end
      WRITE: begin
        busy_d      = 1'b1;
        mem_write_d = 1'b1;
        addr_d      = word_addr(dst_d, 32'(idx_d));
        wdata_d     = data_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign Address    = addr_q;
  assign Write_data = wdata_q;

`ifdef MEM_COPY_ORDER_CHECK_EN
  logic start_accept;
  logic capture;
  logic err_order_w;

  assign start_accept = (state_q == IDLE) && start;
  // A word counts as captured only when READ actually completes.
  assign capture      = (state_q == READ) && !abort;

  order_checker u_order_checker (
    .clk   (clk),
    .reset (reset),
    .clear (start_accept),
    .valid (capture),
    .data  (Read_data),
    .err   (err_order_w)
  );

  assign err_order = err_order_w;
`else
  assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_master
// Directed bench for mem_copy_master with a combinational source memory and a
// bus monitor that logs every read/write strobe.
// -----------------------------------------------------------------------------
module tb_mem_copy_master;

  localparam int LEN_W = 10;

`ifdef MEM_COPY_ORDER_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [31:0]      src_base;
  logic [31:0]      dst_base;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic             err_order;
  logic [31:0]      Address;
  logic [31:0]      Write_data;
  logic             MemRead;
  logic             MemWrite;
  logic [31:0]      Read_data;

  always #5 clk = ~clk;

  mem_copy_master #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err_order  (err_order),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data)
  );

  // Source memory: 256 words, indexed by Address[9:2].
  logic [31:0] src_mem [0:255];
  assign Read_data = src_mem[Address[9:2]];

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  int done_cnt    = 0;
  int busy_cnt    = 0;
  int overlap_cnt = 0;
  int idle_bus_cnt = 0;
  bit mon_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (mon_en) begin
      if (MemWrite) begin
        wr_addr_q.push_back(Address);
        wr_data_q.push_back(Write_data);
      end
      if (MemRead) rd_addr_q.push_back(Address);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (MemRead && MemWrite) overlap_cnt++;
      if (!MemRead && !MemWrite && (Address != 32'h0 || Write_data != 32'h0)) idle_bus_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  // Start is held for exactly one edge (E0); returns #1 after E0.
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n);
    src_base = s;
    dst_base = d;
    length   = LEN_W'(n);
    start    = 1'b1;
    step(1);
    start    = 1'b0;
    $display("copy src=0x%08h dst=0x%08h len=%0d", s, d, n);
  endtask

  // Cycles elapsed after E0 until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      step(1);
      cyc++;
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int c;
    for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
    src_mem[64]  = 32'd1;
    src_mem[65]  = 32'd2;
    src_mem[66]  = 32'd3;
    src_mem[67]  = 32'd4;
    src_mem[192] = 32'd5;
    src_mem[193] = 32'd3;
    src_mem[194] = 32'd7;
    src_mem[255] = 32'hAAAA_0001;
    src_mem[0]   = 32'hAAAA_0002;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; length = '0;
    step(3);
    mon_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_order), 32'd0);
    check("rst_rd", 32'(MemRead), 32'd0);
    check("rst_wr", 32'(MemWrite), 32'd0);
    check("rst_addr", Address, 32'h0);
    check("rst_wdata", Write_data, 32'h0);
    reset = 1'b0;
    step(1);

    // Basic 4-word copy
    clear_logs();
    launch(32'h100, 32'h200, 4);
    check("basic_rd0_strobe", 32'(MemRead), 32'd1);
    check("basic_rd0_addr", Address, 32'h100);
    wait_done(c);
    check("basic_latency", 32'(c), 32'd9);
    check("basic_err", 32'(err_order), 32'd0);
    step(1);
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_done_once", 32'(done_cnt), 32'd1);
    check("basic_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_rd_addr%0d", i), qget(rd_addr_q, i), 32'h100 + 32'(4 * i));
      check($sformatf("basic_wr_addr%0d", i), qget(wr_addr_q, i), 32'h200 + 32'(4 * i));
      check($sformatf("basic_wr_data%0d", i), qget(wr_data_q, i), 32'(i + 1));
    end

    // Empty copy
    clear_logs();
    launch(32'h100, 32'h200, 0);
    check("empty_busy0", 32'(busy), 32'd0);
    check("empty_rd0", 32'(MemRead), 32'd0);
    wait_done(c);
    check("empty_latency", 32'(c), 32'd1);
    step(1);
    check("empty_nrd", 32'(rd_addr_q.size()), 32'd0);
    check("empty_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("empty_busy_cnt", 32'(busy_cnt), 32'd0);
    check("empty_done_once", 32'(done_cnt), 32'd1);

    // Order check: {5,3,7}
    clear_logs();
    launch(32'h300, 32'h400, 3);
    step(2);
    check("order_err_in_rd2", 32'(err_order), 32'd0);
    step(1);
    check("order_err_after_rd2", 32'(err_order), EXP_ERR);
    wait_done(c);
    check("order_latency", 32'(c + 3), 32'd7);
    check("order_err_sticky", 32'(err_order), EXP_ERR);
    step(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("order_wr_data%0d", i), qget(wr_data_q, i), src_mem[192 + i]);
    end
    launch(32'h100, 32'h200, 1);
    check("order_clear_on_start", 32'(err_order), 32'd0);
    wait_done(c);
    step(1);

    // Abort during the second WRITE
    clear_logs();
    launch(32'h100, 32'h200, 4);
    step(3);
    check("abort_in_wr2", 32'(MemWrite), 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr", 32'(MemWrite), 32'd0);
    check("abort_rd", 32'(MemRead), 32'd0);
    check("abort_addr", Address, 32'h0);
    step(4);
    check("abort_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    launch(32'h100, 32'h200, 1);
    wait_done(c);
    check("abort_restart_latency", 32'(c), 32'd3);
    step(1);

    // Start while busy is ignored
    clear_logs();
    launch(32'h100, 32'h200, 4);
    step(1);
    src_base = 32'h300; dst_base = 32'h500; length = LEN_W'(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(c);
    check("busy_start_latency", 32'(c + 2), 32'd9);
    step(1);
    check("busy_start_nwr", 32'(wr_addr_q.size()), 32'd4);
    check("busy_start_wr_addr3", qget(wr_addr_q, 3), 32'h20C);
    check("busy_start_rd_addr3", qget(rd_addr_q, 3), 32'h10C);

    // Start during FIN is ignored
    clear_logs();
    launch(32'h100, 32'h200, 1);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("fin_start_done", 32'(done), 32'd1);
    check("fin_start_ignored", 32'(busy), 32'd0);
    step(3);
    check("fin_start_nrd", 32'(rd_addr_q.size()), 32'd1);

    // Reset mid-copy
    clear_logs();
    launch(32'h100, 32'h200, 4);
    step(1);
    check("rstmid_wr_active", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    step(1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_wr", 32'(MemWrite), 32'd0);
    check("rstmid_rd", 32'(MemRead), 32'd0);
    check("rstmid_addr", Address, 32'h0);
    check("rstmid_wdata", Write_data, 32'h0);
    reset = 1'b0;
    step(12);
    check("rstmid_no_done", 32'(done_cnt), 32'd0);

    // Address wrap and base alignment
    clear_logs();
    launch(32'hFFFF_FFFC, 32'h203, 2);
    wait_done(c);
    check("wrap_latency", 32'(c), 32'd5);
    step(1);
    check("wrap_rd_addr0", qget(rd_addr_q, 0), 32'hFFFF_FFFC);
    check("wrap_rd_addr1", qget(rd_addr_q, 1), 32'h0000_0000);
    check("wrap_wr_addr0", qget(wr_addr_q, 0), 32'h200);
    check("wrap_wr_addr1", qget(wr_addr_q, 1), 32'h204);
    check("wrap_wr_data0", qget(wr_data_q, 0), 32'hAAAA_0001);
    check("wrap_wr_data1", qget(wr_data_q, 1), 32'hAAAA_0002);

    check("bus_no_overlap", 32'(overlap_cnt), 32'd0);
    check("bus_idle_zero", 32'(idle_bus_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
